sys_west_feeder: RTL and testbench

Drives the west edge of the systolic PE array. Accepts one ROWS-wide activation vector per cycle over a valid/ready handshake and skews lane r by r cycles, so each PE row sees its operand aligned with the partial sum arriving from the north. Generates per-row valid and weight-switch flags. A switch flag is sent with the first vector after a new weight set has been staged, so PEs swap their inactive weight register into use on that same beat.

---
 rtl/sys_west_feeder.sv | 161 ++++++++++++++++
 tb/tb_sys_west_feeder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_west_feeder.sv
// rtl/sys_west_feeder.sv - west-edge activation feeder with per-row skew for the systolic PE array
//
// Accepts one ROWS-wide activation vector per cycle and delays lane r by r+1
// register stages, so each PE row sees its operand aligned with the partial sum
// arriving from the north. Valid, data and weight-switch travel together.
//
// Optional feature macro: FEEDER_BEAT_CNT_EN
//   defined   : 16-bit saturating beat counter; tile_beats holds the beat count
//               of the most recently completed tile.
//   undefined : no counter; tile_beats is tied to 0.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   in_valid     activation vector present
//   in_ready     feeder accepts a vector this cycle (low while draining)
//   in_data      ROWS lanes of DATA_W bits, lane r = in_data[r*DATA_W +: DATA_W]
//   in_last      marks the final vector of a tile
//   w_swap_req   pulse: a new weight set is staged in the PE inactive registers
//   row_data     skewed west operand per row
//   row_valid    per-row valid
//   row_switch   per-row weight-switch flag (with the first beat after a swap request)
//   busy         FSM not idle or any skew stage holds a valid beat
//   tile_done    one-cycle pulse as the last beat of a tile leaves row ROWS-1
//   tile_beats   beats accepted in the most recent completed tile
module sys_west_feeder #(
  parameter int ROWS   = 4,
  parameter int DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] in_data,
  input  logic                   in_last,
  input  logic                   w_swap_req,
  output logic [ROWS*DATA_W-1:0] row_data,
  output logic [ROWS-1:0]        row_valid,
  output logic [ROWS-1:0]        row_switch,
  output logic                   busy,
  output logic                   tile_done,
  output logic [15:0]            tile_beats
);

  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

  state_t          state;
  logic [CW-1:0]   drain_cnt;
  logic            switch_pending;
  logic            accept;
  logic            beat_switch;
  logic            done_next;
  logic [ROWS-1:0] lane_busy;

  assign accept      = in_valid && in_ready;
  // A request in the same cycle as an accept applies to that very beat.
  assign beat_switch = switch_pending | w_swap_req;

  // tile_done is registered: it rises the cycle the drain counter reads 0. With
  // ROWS=1 the drain is a single cycle, so it is raised by the last accept itself.
  assign done_next = (state == S_DRAIN) ? (drain_cnt == CW'(1))
                                        : (accept && in_last && (ROWS == 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      drain_cnt      <= '0;
      in_ready       <= 1'b0;
      tile_done      <= 1'b0;
      switch_pending <= 1'b0;
    end else begin
      switch_pending <= beat_switch & ~accept;
      tile_done      <= done_next;
      case (state)
        S_IDLE, S_STREAM: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (in_last) begin
              state     <= S_DRAIN;
              drain_cnt <= CW'(ROWS - 1);
              in_ready  <= 1'b0;
            end else begin
              state <= S_STREAM;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Lane r: r+1 stages. Non-accept cycles inject a bubble whose data and switch
  // are zero, so invalid stages never carry stale operands.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [DATA_W-1:0] d_q [0:r];
    logic [r:0]        v_q;
    logic [r:0]        s_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= '0;
        s_q <= '0;
        for (int i = 0; i <= r; i++) d_q[i] <= '0;
      end else begin
        v_q[0] <= accept;
        s_q[0] <= accept & beat_switch;
        d_q[0] <= accept ? in_data[r*DATA_W +: DATA_W] : '0;
        for (int i = 1; i <= r; i++) begin
          v_q[i] <= v_q[i-1];
          s_q[i] <= s_q[i-1];
          d_q[i] <= d_q[i-1];
        end
      end
    end

    assign row_data[r*DATA_W +: DATA_W] = d_q[r];
    assign row_valid[r]                 = v_q[r];
    assign row_switch[r]                = s_q[r];
    assign lane_busy[r]                 = |v_q;
  end

  assign busy = (state != S_IDLE) || (|lane_busy);

`ifdef FEEDER_BEAT_CNT_EN
  logic [15:0] beat_cnt;
  logic [15:0] beat_cnt_nxt;

  // The first beat of a tile restarts the count; later beats saturate at 0xFFFF.
  always_comb begin
    beat_cnt_nxt = beat_cnt;
    if (accept) begin
      if (state == S_IDLE)
        beat_cnt_nxt = 16'd1;
      else if (beat_cnt != 16'hFFFF)
        beat_cnt_nxt = beat_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt   <= '0;
      tile_beats <= '0;
    end else begin
      beat_cnt <= beat_cnt_nxt;
      if (done_next) tile_beats <= beat_cnt_nxt;
    end
  end
`else
  assign tile_beats = 16'd0;
`endif

endmodule

// File: tb/tb_sys_west_feeder.sv
// tb/tb_sys_west_feeder.sv - self-checking bench for sys_west_feeder against a beat-history model
module tb_sys_west_feeder;

  localparam int ROWS   = 4;
  localparam int DATA_W = 16;
  localparam int HN     = 64;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_last = 1'b0;
  logic                   w_swap_req = 1'b0;
  logic [ROWS*DATA_W-1:0] in_data = '0;
  logic                   in_ready;
  logic [ROWS*DATA_W-1:0] row_data;
  logic [ROWS-1:0]        row_valid;
  logic [ROWS-1:0]        row_switch;
  logic                   busy;
  logic                   tile_done;
  logic [15:0]            tile_beats;

  sys_west_feeder #(.ROWS(ROWS), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .w_swap_req (w_swap_req),
    .row_data   (row_data),
    .row_valid  (row_valid),
    .row_switch (row_switch),
    .busy       (busy),
    .tile_done  (tile_done),
    .tile_beats (tile_beats)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remembers what was accepted at each clock edge. Row r in the cycle
  // after edge k shows whatever was accepted at edge k-r.
  int                     k = -1;
  bit                     started = 1'b0;
  bit                     hv [HN];
  bit                     hs [HN];
  logic [ROWS*DATA_W-1:0] hd [HN];
  bit                     ready_m = 1'b0;
  bit                     done_m = 1'b0;
  bit                     tile_open = 1'b0;
  int                     last_edge = -1000;
  int                     last_req = -1;
  int                     last_acc = -1;
  int                     beats = 0;
  logic [15:0]            tbeats_m = '0;
  bit                     acc_m;
  bit                     sw_m;

  always @(posedge clk) begin
    k++;
    started = 1'b1;
    if (rst) begin
      for (int i = 0; i < HN; i++) begin
        hv[i] = 1'b0;
        hs[i] = 1'b0;
        hd[i] = '0;
      end
      ready_m   = 1'b0;
      done_m    = 1'b0;
      tile_open = 1'b0;
      last_edge = -1000;
      last_req  = k;
      last_acc  = k;
      beats     = 0;
      tbeats_m  = '0;
    end else begin
      acc_m = in_valid && ready_m;
      if (w_swap_req) last_req = k;
      // A beat switches if any request arrived since the previous accept.
      sw_m = acc_m && (last_req > last_acc);
      hv[k % HN] = acc_m;
      hs[k % HN] = sw_m;
      hd[k % HN] = acc_m ? in_data : '0;
      if (acc_m) begin
        last_acc  = k;
        beats     = tile_open ? ((beats < 65535) ? beats + 1 : beats) : 1;
        tile_open = !in_last;
        if (in_last) last_edge = k;
      end
      ready_m = (k >= last_edge + ROWS);
      done_m  = (k == last_edge + ROWS - 1);
`ifdef FEEDER_BEAT_CNT_EN
      if (done_m) tbeats_m = 16'(beats);
`endif
    end
  end

  logic [ROWS-1:0]        ev;
  logic [ROWS-1:0]        es;
  logic [ROWS*DATA_W-1:0] ed;
  bit                     anyv;
  bit                     busy_m;
  int                     cidx;

  always @(negedge clk) begin
    if (started) begin
      ev   = '0;
      es   = '0;
      ed   = '0;
      anyv = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        cidx = k - r;
        if (cidx >= 0) begin
          if (hv[cidx % HN]) begin
            ev[r] = 1'b1;
            es[r] = hs[cidx % HN];
            ed[r*DATA_W +: DATA_W] = hd[cidx % HN][r*DATA_W +: DATA_W];
          end
          anyv = anyv | hv[cidx % HN];
        end
      end
      busy_m = tile_open || (k <= last_edge + ROWS - 1) || anyv;
      check("row_valid",  64'(row_valid),  64'(ev));
      check("row_data",   row_data,        ed);
      check("row_switch", 64'(row_switch), 64'(es));
      check("in_ready",   64'(in_ready),   64'(ready_m));
      check("busy",       64'(busy),       64'(busy_m));
      check("tile_done",  64'(tile_done),  64'(done_m));
      check("tile_beats", 64'(tile_beats), 64'(tbeats_m));
    end
  end

  task automatic drive(input bit v, input logic [63:0] d, input bit l, input bit req);
    @(negedge clk);
    #1;
    in_valid   = v;
    in_data    = d;
    in_last    = l;
    w_swap_req = req;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 64'h0, 1'b0, 1'b0);
  endtask

  logic [63:0] va, vb, vc, vexp;
  logic [15:0] exp5, exp1;

  initial begin
    va = 64'hA003_A002_A001_A000;
    vb = 64'hB003_B002_B001_B000;
    vc = 64'hC003_C002_C001_C000;
`ifdef FEEDER_BEAT_CNT_EN
    exp5 = 16'd5;
    exp1 = 16'd1;
`else
    exp5 = 16'd0;
    exp1 = 16'd0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check("rst_in_ready", 64'(in_ready), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_row_valid", 64'(row_valid), 64'h0);
    check("rst_tile_beats", 64'(tile_beats), 64'h0);
    rst = 1'b0;
    idle(1);
    check("ready_after_rst", 64'(in_ready), 64'h1);
    idle(1);

    // Three-beat tile A, B, C
    drive(1'b1, va, 1'b0, 1'b0);
    drive(1'b1, vb, 1'b0, 1'b0);
    drive(1'b1, vc, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    for (int j = 0; j <= 4; j++) begin
      if (j > 0) begin
        @(negedge clk);
        #1;
      end
      check("abc_in_ready", 64'(in_ready), (j == 4) ? 64'h1 : 64'h0);
      check("abc_tile_done", 64'(tile_done), (j == 3) ? 64'h1 : 64'h0);
      if (j == 1) begin
        vexp = {va[63:48], vb[47:32], vc[31:16], 16'h0000};
        check("abc_skew_data", row_data, vexp);
        check("abc_skew_valid", 64'(row_valid), 64'hE);
      end
    end
    idle(2);

    // Swap request two cycles before the first accept
    drive(1'b0, 64'h0, 1'b0, 1'b1);
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    drive(1'b1, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
    drive(1'b1, 64'h5555_6666_7777_8888, 1'b1, 1'b0);
    check("swap_beat0_row0", 64'(row_switch), 64'h1);
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    check("swap_beat1_clear", 64'(row_switch), 64'h2);
    idle(6);

    // Request with a mid-tile accept, then a pending request across tiles
    drive(1'b1, 64'h0F00_0F01_0F02_0F03, 1'b0, 1'b0);
    drive(1'b1, 64'h0F10_0F11_0F12_0F13, 1'b0, 1'b1);
    drive(1'b1, 64'h0F20_0F21_0F22_0F23, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 1'b0, 1'b1);
    idle(6);
    drive(1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    check("pending_next_tile", 64'(row_switch), 64'h1);
    idle(6);

    // Bubble pattern 1, 0, 1
    vb = 64'h1D03_1D02_1D01_1D00;
    drive(1'b1, vb, 1'b0, 1'b0);
    drive(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    drive(1'b1, 64'h2D03_2D02_2D01_2D00, 1'b1, 1'b0);
    check("bubble_valid", 64'(row_valid), 64'h2);
    vexp = {32'h0, vb[31:16], 16'h0000};
    check("bubble_data", row_data, vexp);
    idle(6);

    // Reset during drain with beats in flight
    drive(1'b1, 64'h3A03_3A02_3A01_3A00, 1'b0, 1'b0);
    drive(1'b1, 64'h3B03_3B02_3B01_3B00, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(row_valid), 64'h0);
    check("midrst_data", row_data, 64'h0);
    check("midrst_switch", 64'(row_switch), 64'h0);
    check("midrst_busy", 64'(busy), 64'h0);
    check("midrst_done", 64'(tile_done), 64'h0);
    check("midrst_ready", 64'(in_ready), 64'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    drive(1'b1, 64'h4C03_4C02_4C01_4C00, 1'b1, 1'b0);
    idle(6);

    // Beat counts: 5-beat tile then 1-beat tile
    for (int b = 0; b < 5; b++)
      drive(1'b1, {$urandom, $urandom}, (b == 4), 1'b0);
    idle(6);
    check("tile_beats_5", 64'(tile_beats), 64'(exp5));
    drive(1'b1, {$urandom, $urandom}, 1'b1, 1'b0);
    idle(6);
    check("tile_beats_1", 64'(tile_beats), 64'(exp1));

    // Randomized traffic with occasional resets
    for (int n = 0; n < 800; n++) begin
      drive($urandom_range(0, 9) < 7, {$urandom, $urandom},
            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 149) == 0);
    end
    rst = 1'b0;
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
